// File: rtl/axi_esp_dma_bridge_if.sv
// Bundles the AXI4 slave channels and the ESP DMA read/write ctrl+chnl channels of the bridge.
// slave = bridge side, master = cluster/DMA side that drives requests and DMA responses.
interface axi_esp_dma_bridge_if #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 4
);
    logic                        s_aw_valid, s_aw_ready;
    logic [AXI_ID_WIDTH-1:0]     s_aw_id;
    logic [AXI_ADDR_WIDTH-1:0]   s_aw_addr;
    logic [7:0]                  s_aw_len;
    logic [2:0]                  s_aw_size;
    logic                        s_w_valid, s_w_ready, s_w_last;
    logic [AXI_DATA_WIDTH-1:0]   s_w_data;
    logic [AXI_DATA_WIDTH/8-1:0] s_w_strb;
    logic                        s_b_valid, s_b_ready;
    logic [AXI_ID_WIDTH-1:0]     s_b_id;
    logic [1:0]                  s_b_resp;
    logic                        s_ar_valid, s_ar_ready;
    logic [AXI_ID_WIDTH-1:0]     s_ar_id;
    logic [AXI_ADDR_WIDTH-1:0]   s_ar_addr;
    logic [7:0]                  s_ar_len;
    logic [2:0]                  s_ar_size;
    logic                        s_r_valid, s_r_ready, s_r_last;
    logic [AXI_DATA_WIDTH-1:0]   s_r_data;
    logic [AXI_ID_WIDTH-1:0]     s_r_id;
    logic [1:0]                  s_r_resp;
    logic                        dma_read_ctrl_valid, dma_read_ctrl_ready;
    logic [31:0]                 dma_read_ctrl_data_index, dma_read_ctrl_data_length;
    logic [2:0]                  dma_read_ctrl_data_size;
    logic                        dma_read_chnl_valid, dma_read_chnl_ready;
    logic [AXI_DATA_WIDTH-1:0]   dma_read_chnl_data;
    logic                        dma_write_ctrl_valid, dma_write_ctrl_ready;
    logic [31:0]                 dma_write_ctrl_data_index, dma_write_ctrl_data_length;
    logic [2:0]                  dma_write_ctrl_data_size;
    logic                        dma_write_chnl_valid, dma_write_chnl_ready;
    logic [AXI_DATA_WIDTH-1:0]   dma_write_chnl_data;

    modport slave (
        input  s_aw_valid, s_aw_id, s_aw_addr, s_aw_len, s_aw_size, output s_aw_ready,
        input  s_w_valid, s_w_data, s_w_strb, s_w_last, output s_w_ready,
        output s_b_valid, s_b_id, s_b_resp, input s_b_ready,
        input  s_ar_valid, s_ar_id, s_ar_addr, s_ar_len, s_ar_size, output s_ar_ready,
        output s_r_valid, s_r_data, s_r_id, s_r_resp, s_r_last, input s_r_ready,
        output dma_read_ctrl_valid, dma_read_ctrl_data_index, dma_read_ctrl_data_length,
        output dma_read_ctrl_data_size, input dma_read_ctrl_ready,
        input  dma_read_chnl_valid, dma_read_chnl_data, output dma_read_chnl_ready,
        output dma_write_ctrl_valid, dma_write_ctrl_data_index, dma_write_ctrl_data_length,
        output dma_write_ctrl_data_size, input dma_write_ctrl_ready,
        output dma_write_chnl_valid, dma_write_chnl_data, input dma_write_chnl_ready
    );

    modport master (
        output s_aw_valid, s_aw_id, s_aw_addr, s_aw_len, s_aw_size, input s_aw_ready,
        output s_w_valid, s_w_data, s_w_strb, s_w_last, input s_w_ready,
        input  s_b_valid, s_b_id, s_b_resp, output s_b_ready,
        output s_ar_valid, s_ar_id, s_ar_addr, s_ar_len, s_ar_size, input s_ar_ready,
        input  s_r_valid, s_r_data, s_r_id, s_r_resp, s_r_last, output s_r_ready,
        input  dma_read_ctrl_valid, dma_read_ctrl_data_index, dma_read_ctrl_data_length,
        input  dma_read_ctrl_data_size, output dma_read_ctrl_ready,
        output dma_read_chnl_valid, dma_read_chnl_data, input dma_read_chnl_ready,
        input  dma_write_ctrl_valid, dma_write_ctrl_data_index, dma_write_ctrl_data_length,
        input  dma_write_ctrl_data_size, output dma_write_ctrl_ready,
        input  dma_write_chnl_valid, dma_write_chnl_data, output dma_write_chnl_ready
    );
endinterface

// File: rtl/axi_esp_dma_bridge.sv
// AXI4 slave to ESP DMA bridge: per-direction pending FIFO, one DMA ctrl per burst, beat pass-through.
// Latency: AW/AR handshake to ctrl_valid is 2 cycles; data beats are combinational pass-through.
// Backpressure: s_aw/ar_ready drop when the FIFO is full; W/R beats stall outside the data phase.
module axi_esp_dma_bridge #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 4,
    parameter int PENDING_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    axi_esp_dma_bridge_if.slave   bus
);
    localparam int BYTES = AXI_DATA_WIDTH / 8;
    localparam int OFF   = $clog2(BYTES);
    localparam int PW    = $clog2(PENDING_DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(PENDING_DEPTH);

    typedef struct packed {
        logic [AXI_ID_WIDTH-1:0]   id;
        logic [AXI_ADDR_WIDTH-1:0] addr;
        logic [7:0]                len;
        logic [2:0]                size;
    } req_t;

    typedef enum logic [1:0] {W_IDLE, W_CTRL, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_CTRL, R_DATA} r_state_t;

    function automatic logic [31:0] to_index(input logic [AXI_ADDR_WIDTH-1:0] a);
        logic [AXI_ADDR_WIDTH-1:0] s;
        s = a >> OFF;
        return 32'(s);
    endfunction

    req_t aw_mem [PENDING_DEPTH];
    req_t ar_mem [PENDING_DEPTH];
    logic [PW-1:0] aw_wp, aw_rp, ar_wp, ar_rp;
    logic [PW:0]   aw_cnt, ar_cnt;
    logic aw_push, aw_pop, ar_push, ar_pop;
    req_t aw_head, ar_head;

    w_state_t w_state;
    r_state_t r_state;
    logic        wr_ctrl_valid, wr_err, b_valid, rd_ctrl_valid;
    logic [31:0] wr_index, wr_length, rd_index, rd_length;
    logic [2:0]  wr_size, rd_size;
    logic [AXI_ID_WIDTH-1:0] wr_id, rd_id;
    logic [7:0]  wr_len, rd_len;
    logic [8:0]  wr_cnt, rd_cnt;
    logic        w_hs, r_hs, r_last;
    logic [AXI_DATA_WIDTH-1:0] w_masked;

    // Readies are held low while reset is applied so no request slips in.
    assign bus.s_aw_ready = rst && (aw_cnt != FULL_CNT);
    assign bus.s_ar_ready = rst && (ar_cnt != FULL_CNT);
    assign aw_push = bus.s_aw_valid && bus.s_aw_ready;
    assign ar_push = bus.s_ar_valid && bus.s_ar_ready;
    assign aw_pop  = (w_state == W_IDLE) && (aw_cnt != '0);
    assign ar_pop  = (r_state == R_IDLE) && (ar_cnt != '0);
    assign aw_head = aw_mem[aw_rp];
    assign ar_head = ar_mem[ar_rp];

    always_ff @(posedge clk) begin
        if (aw_push) aw_mem[aw_wp] <= '{bus.s_aw_id, bus.s_aw_addr, bus.s_aw_len, bus.s_aw_size};
        if (ar_push) ar_mem[ar_wp] <= '{bus.s_ar_id, bus.s_ar_addr, bus.s_ar_len, bus.s_ar_size};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            aw_wp <= '0; aw_rp <= '0; aw_cnt <= '0;
            ar_wp <= '0; ar_rp <= '0; ar_cnt <= '0;
        end else begin
            if (aw_push) aw_wp <= aw_wp + PW'(1);
            if (aw_pop)  aw_rp <= aw_rp + PW'(1);
            if (ar_push) ar_wp <= ar_wp + PW'(1);
            if (ar_pop)  ar_rp <= ar_rp + PW'(1);
            if (aw_push && !aw_pop)      aw_cnt <= aw_cnt + (PW+1)'(1);
            else if (!aw_push && aw_pop) aw_cnt <= aw_cnt - (PW+1)'(1);
            if (ar_push && !ar_pop)      ar_cnt <= ar_cnt + (PW+1)'(1);
            else if (!ar_push && ar_pop) ar_cnt <= ar_cnt - (PW+1)'(1);
        end
    end

    assign w_hs = (w_state == W_DATA) && bus.s_w_valid && bus.dma_write_chnl_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            w_state <= W_IDLE; wr_ctrl_valid <= 1'b0; wr_err <= 1'b0; b_valid <= 1'b0;
            wr_index <= '0; wr_length <= '0; wr_size <= '0; wr_id <= '0; wr_len <= '0; wr_cnt <= '0;
        end else begin
            case (w_state)
                W_IDLE: if (aw_pop) begin
                    wr_index      <= to_index(aw_head.addr);
                    wr_length     <= 32'(aw_head.len) + 32'd1;
                    wr_size       <= aw_head.size;
                    wr_id         <= aw_head.id;
                    wr_len        <= aw_head.len;
                    wr_err        <= 1'b0;
                    wr_ctrl_valid <= 1'b1;
                    w_state       <= W_CTRL;
                end
                W_CTRL: if (bus.dma_write_ctrl_ready) begin
                    wr_ctrl_valid <= 1'b0;
                    wr_cnt        <= '0;
                    w_state       <= W_DATA;
                end
                // The burst ends on the beat count alone; a misplaced WLAST only marks the response.
                W_DATA: if (w_hs) begin
                    wr_cnt <= wr_cnt + 9'd1;
                    if (wr_cnt == {1'b0, wr_len}) begin
                        if (!bus.s_w_last) wr_err <= 1'b1;
                        b_valid <= 1'b1;
                        w_state <= W_RESP;
                    end else if (bus.s_w_last) begin
                        wr_err <= 1'b1;
                    end
                end
                W_RESP: if (bus.s_b_ready) begin
                    b_valid <= 1'b0;
                    w_state <= W_IDLE;
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_comb begin
        w_masked = '0;
        if (w_state == W_DATA)
            for (int i = 0; i < BYTES; i++)
                w_masked[8*i +: 8] = bus.s_w_strb[i] ? bus.s_w_data[8*i +: 8] : 8'h00;
    end

    assign bus.dma_write_ctrl_valid       = wr_ctrl_valid;
    assign bus.dma_write_ctrl_data_index  = wr_index;
    assign bus.dma_write_ctrl_data_length = wr_length;
    assign bus.dma_write_ctrl_data_size   = wr_size;
    assign bus.dma_write_chnl_valid       = (w_state == W_DATA) && bus.s_w_valid;
    assign bus.dma_write_chnl_data        = w_masked;
    assign bus.s_w_ready                  = (w_state == W_DATA) && bus.dma_write_chnl_ready;
    assign bus.s_b_valid                  = b_valid;
    assign bus.s_b_id                     = wr_id;
    assign bus.s_b_resp                   = {wr_err, 1'b0};

    assign r_hs   = (r_state == R_DATA) && bus.dma_read_chnl_valid && bus.s_r_ready;
    assign r_last = (r_state == R_DATA) && (rd_cnt == {1'b0, rd_len});

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= R_IDLE; rd_ctrl_valid <= 1'b0;
            rd_index <= '0; rd_length <= '0; rd_size <= '0; rd_id <= '0; rd_len <= '0; rd_cnt <= '0;
        end else begin
            case (r_state)
                R_IDLE: if (ar_pop) begin
                    rd_index      <= to_index(ar_head.addr);
                    rd_length     <= 32'(ar_head.len) + 32'd1;
                    rd_size       <= ar_head.size;
                    rd_id         <= ar_head.id;
                    rd_len        <= ar_head.len;
                    rd_ctrl_valid <= 1'b1;
                    r_state       <= R_CTRL;
                end
                R_CTRL: if (bus.dma_read_ctrl_ready) begin
                    rd_ctrl_valid <= 1'b0;
                    rd_cnt        <= '0;
                    r_state       <= R_DATA;
                end
                R_DATA: if (r_hs) begin
                    rd_cnt <= rd_cnt + 9'd1;
                    if (r_last) r_state <= R_IDLE;
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    assign bus.dma_read_ctrl_valid       = rd_ctrl_valid;
    assign bus.dma_read_ctrl_data_index  = rd_index;
    assign bus.dma_read_ctrl_data_length = rd_length;
    assign bus.dma_read_ctrl_data_size   = rd_size;
    assign bus.dma_read_chnl_ready       = (r_state == R_DATA) && bus.s_r_ready;
    assign bus.s_r_valid                 = (r_state == R_DATA) && bus.dma_read_chnl_valid;
    assign bus.s_r_data                  = (r_state == R_DATA) ? bus.dma_read_chnl_data : '0;
    assign bus.s_r_id                    = rd_id;
    assign bus.s_r_resp                  = 2'b00;
    assign bus.s_r_last                  = r_last;
endmodule

// File: tb/tb_axi_esp_dma_bridge.sv
// Scoreboard bench for axi_esp_dma_bridge: stimulus queues drive requests/beats, monitors pop expectations.
module tb_axi_esp_dma_bridge;
    localparam int AW = 32, DW = 64, IW = 4, PD = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    axi_esp_dma_bridge_if #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW)) bus ();

    axi_esp_dma_bridge #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW),
                         .PENDING_DEPTH(PD)) dut (.clk(clk), .rst(rst), .bus(bus));

    int total = 0;
    int bad   = 0;
    logic bp = 1'b0;
    logic hold_rctrl = 1'b0;
    time  aw_hs_t = 0, ar_hs_t = 0;

    logic [46:0] aw_q[$], ar_q[$];
    logic [72:0] w_q[$];
    logic [63:0] rd_q[$];
    logic [66:0] exp_wctrl_q[$], exp_rctrl_q[$];
    logic [63:0] exp_wchnl_q[$];
    logic [5:0]  exp_b_q[$];
    logic [70:0] exp_r_q[$];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic unexpected(input string nm);
        total++;
        bad++;
        $display("FAIL %s unexpected handshake with no expectation queued", nm);
    endtask

    function automatic logic all_empty();
        return aw_q.size() == 0 && ar_q.size() == 0 && w_q.size() == 0 && rd_q.size() == 0 &&
               exp_wctrl_q.size() == 0 && exp_rctrl_q.size() == 0 && exp_wchnl_q.size() == 0 &&
               exp_b_q.size() == 0 && exp_r_q.size() == 0;
    endfunction

    task automatic wait_drain(input string nm, input int maxc);
        int n = 0;
        while (n < maxc && !all_empty()) begin
            @(negedge clk);
            n++;
        end
        chk(nm, 128'(all_empty()), 128'(1));
    endtask

    task automatic send_aw(input logic [3:0] id, input logic [31:0] a, input logic [7:0] l,
                           input logic [2:0] sz, input logic [31:0] idx);
        aw_q.push_back({id, a, l, sz});
        exp_wctrl_q.push_back({idx, 32'(l) + 32'd1, sz});
    endtask

    task automatic send_ar(input logic [3:0] id, input logic [31:0] a, input logic [7:0] l,
                           input logic [2:0] sz, input logic [31:0] idx);
        ar_q.push_back({id, a, l, sz});
        exp_rctrl_q.push_back({idx, 32'(l) + 32'd1, sz});
    endtask

    task automatic send_w(input logic [63:0] d, input logic [7:0] s, input logic last,
                          input logic [63:0] exp_d);
        w_q.push_back({d, s, last});
        exp_wchnl_q.push_back(exp_d);
    endtask

    task automatic read_beat(input logic [63:0] d, input logic [3:0] id, input logic last);
        rd_q.push_back(d);
        exp_r_q.push_back({d, id, 2'b00, last});
    endtask

    // Input driver: handshakes are judged at the negedge, inputs change 1 time unit after posedge.
    initial begin
        logic aw_hs, ar_hs, w_hs, rc_hs;
        bus.s_aw_valid = 0; bus.s_aw_id = '0; bus.s_aw_addr = '0; bus.s_aw_len = '0; bus.s_aw_size = '0;
        bus.s_ar_valid = 0; bus.s_ar_id = '0; bus.s_ar_addr = '0; bus.s_ar_len = '0; bus.s_ar_size = '0;
        bus.s_w_valid = 0; bus.s_w_data = '0; bus.s_w_strb = '0; bus.s_w_last = 0;
        bus.dma_read_chnl_valid = 0; bus.dma_read_chnl_data = '0;
        bus.s_b_ready = 0; bus.s_r_ready = 0;
        bus.dma_read_ctrl_ready = 0; bus.dma_write_ctrl_ready = 0; bus.dma_write_chnl_ready = 0;
        forever begin
            @(negedge clk);
            aw_hs = bus.s_aw_valid && bus.s_aw_ready;
            ar_hs = bus.s_ar_valid && bus.s_ar_ready;
            w_hs  = bus.s_w_valid && bus.s_w_ready;
            rc_hs = bus.dma_read_chnl_valid && bus.dma_read_chnl_ready;
            if (aw_hs) aw_hs_t = $time;
            if (ar_hs) ar_hs_t = $time;
            @(posedge clk);
            #1;
            if (aw_hs && aw_q.size() > 0) void'(aw_q.pop_front());
            if (ar_hs && ar_q.size() > 0) void'(ar_q.pop_front());
            if (w_hs && w_q.size() > 0)   void'(w_q.pop_front());
            if (rc_hs && rd_q.size() > 0) void'(rd_q.pop_front());
            bus.s_aw_valid = aw_q.size() > 0;
            {bus.s_aw_id, bus.s_aw_addr, bus.s_aw_len, bus.s_aw_size} = (aw_q.size() > 0) ? aw_q[0] : '0;
            bus.s_ar_valid = ar_q.size() > 0;
            {bus.s_ar_id, bus.s_ar_addr, bus.s_ar_len, bus.s_ar_size} = (ar_q.size() > 0) ? ar_q[0] : '0;
            bus.s_w_valid = w_q.size() > 0;
            {bus.s_w_data, bus.s_w_strb, bus.s_w_last} = (w_q.size() > 0) ? w_q[0] : '0;
            bus.dma_read_chnl_valid = rd_q.size() > 0 && (!bp || $urandom_range(0, 1) == 1);
            bus.dma_read_chnl_data  = (rd_q.size() > 0) ? rd_q[0] : '0;
            bus.dma_read_ctrl_ready  = !hold_rctrl && (!bp || $urandom_range(0, 1) == 1);
            bus.dma_write_ctrl_ready = !bp || $urandom_range(0, 1) == 1;
            bus.dma_write_chnl_ready = !bp || $urandom_range(0, 1) == 1;
            bus.s_b_ready            = !bp || $urandom_range(0, 1) == 1;
            bus.s_r_ready            = !bp || $urandom_range(0, 1) == 1;
        end
    end

    // Output monitor: every DUT-presented handshake pops and checks its scoreboard queue.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                if (bus.dma_write_ctrl_valid && bus.dma_write_ctrl_ready) begin
                    if (exp_wctrl_q.size() == 0) unexpected("wctrl");
                    else chk("wctrl", 128'({bus.dma_write_ctrl_data_index, bus.dma_write_ctrl_data_length,
                                            bus.dma_write_ctrl_data_size}), 128'(exp_wctrl_q.pop_front()));
                end
                if (bus.dma_read_ctrl_valid && bus.dma_read_ctrl_ready) begin
                    if (exp_rctrl_q.size() == 0) unexpected("rctrl");
                    else chk("rctrl", 128'({bus.dma_read_ctrl_data_index, bus.dma_read_ctrl_data_length,
                                            bus.dma_read_ctrl_data_size}), 128'(exp_rctrl_q.pop_front()));
                end
                if (bus.dma_write_chnl_valid && bus.dma_write_chnl_ready) begin
                    if (exp_wchnl_q.size() == 0) unexpected("wchnl");
                    else chk("wchnl", 128'(bus.dma_write_chnl_data), 128'(exp_wchnl_q.pop_front()));
                end
                if (bus.s_b_valid && bus.s_b_ready) begin
                    if (exp_b_q.size() == 0) unexpected("b");
                    else chk("b", 128'({bus.s_b_id, bus.s_b_resp}), 128'(exp_b_q.pop_front()));
                end
                if (bus.s_r_valid && bus.s_r_ready) begin
                    if (exp_r_q.size() == 0) unexpected("r");
                    else chk("r", 128'({bus.s_r_data, bus.s_r_id, bus.s_r_resp, bus.s_r_last}),
                             128'(exp_r_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] t4_addr [6] = '{32'h000, 32'h008, 32'h010, 32'h018, 32'h020, 32'h028};
        logic [7:0]  t4_len  [6] = '{8'd0, 8'd1, 8'd0, 8'd2, 8'd0, 8'd1};
        int n;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_valids", 128'({bus.dma_write_ctrl_valid, bus.dma_read_ctrl_valid, bus.dma_write_chnl_valid,
                                bus.s_b_valid, bus.s_r_valid}), 128'(0));
        chk("rst_readys", 128'({bus.s_aw_ready, bus.s_ar_ready, bus.s_w_ready, bus.dma_read_chnl_ready}), 128'(0));
        chk("rst_index", 128'({bus.dma_read_ctrl_data_index, bus.dma_write_ctrl_data_index}), 128'(0));
        chk("rst_data_id", 128'({bus.s_r_data, bus.s_b_id, bus.s_r_id}), 128'(0));
        rst = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 128'({bus.s_aw_ready, bus.s_ar_ready}), 128'(2'b11));

        // 1: four-beat write
        send_aw(4'd3, 32'h100, 8'd3, 3'd3, 32'h20);
        for (int i = 0; i < 4; i++)
            send_w({32'hCAFE0000, 32'(i)}, 8'hFF, i == 3, {32'hCAFE0000, 32'(i)});
        exp_b_q.push_back({4'd3, 2'b00});
        wait_drain("t1_drain", 200);

        // 2: single-beat read
        send_ar(4'd5, 32'h40, 8'd0, 3'd3, 32'd8);
        read_beat(64'hDEAD, 4'd5, 1'b1);
        wait_drain("t2_drain", 200);

        // 3: strobe masking, plus AW-to-ctrl latency
        @(negedge clk);
        send_aw(4'd1, 32'h08, 8'd0, 3'd3, 32'd1);
        send_w(64'h1122334455667788, 8'h0F, 1'b1, 64'h0000000055667788);
        exp_b_q.push_back({4'd1, 2'b00});
        n = 0;
        while (n < 20 && !bus.dma_write_ctrl_valid) begin
            @(negedge clk);
            n++;
        end
        chk("wctrl_latency", 128'($time - aw_hs_t), 128'(20));
        wait_drain("t3_drain", 200);

        // 4: FIFO fills while read ctrl is held off
        hold_rctrl = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send_ar(4'(i), t4_addr[i], t4_len[i], 3'd3, 32'(i));
            for (int b = 0; b <= int'(t4_len[i]); b++)
                read_beat({32'hBEEF0000 + 32'(i), 32'(b)}, 4'(i), b == int'(t4_len[i]));
        end
        repeat (8) @(negedge clk);
        chk("ar_full_ready", 128'(bus.s_ar_ready), 128'(0));
        chk("ar_stalled_left", 128'(ar_q.size()), 128'(1));
        chk("rctrl_held", 128'(bus.dma_read_ctrl_valid), 128'(1));
        hold_rctrl = 1'b0;
        wait_drain("t4_drain", 400);

        // 5: concurrent write and read with random backpressure
        bp = 1'b1;
        send_aw(4'd2, 32'h300, 8'd1, 3'd3, 32'h60);
        send_ar(4'd6, 32'h308, 8'd1, 3'd3, 32'h61);
        send_w(64'hA5A5_0000_0000_0001, 8'hFF, 1'b0, 64'hA5A5_0000_0000_0001);
        send_w(64'hA5A5_0000_0000_0002, 8'hF0, 1'b1, 64'hA5A5_0000_0000_0000);
        exp_b_q.push_back({4'd2, 2'b00});
        read_beat(64'h5A5A_0000_0000_0001, 4'd6, 1'b0);
        read_beat(64'h5A5A_0000_0000_0002, 4'd6, 1'b1);
        wait_drain("t5_drain", 600);
        chk("aw_ar_same_cycle", 128'(aw_hs_t), 128'(ar_hs_t));
        bp = 1'b0;

        // 6: early WLAST and missing final WLAST give SLVERR, all beats forwarded
        send_aw(4'd4, 32'h400, 8'd2, 3'd3, 32'h80);
        send_w(64'h10, 8'hFF, 1'b0, 64'h10);
        send_w(64'h20, 8'hFF, 1'b1, 64'h20);
        send_w(64'h30, 8'hFF, 1'b0, 64'h30);
        exp_b_q.push_back({4'd4, 2'b10});
        wait_drain("t6_drain", 200);

        // 6b: reset in the middle of a read burst with requests still queued
        send_ar(4'd7, 32'h80, 8'd3, 3'd3, 32'h10);
        ar_q.push_back({4'd8, 32'h88, 8'd0, 3'd3});
        ar_q.push_back({4'd9, 32'h90, 8'd0, 3'd3});
        read_beat(64'h77, 4'd7, 1'b0);
        wait_drain("t6b_drain", 200);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_valids", 128'({bus.dma_write_ctrl_valid, bus.dma_read_ctrl_valid, bus.dma_write_chnl_valid,
                                   bus.s_b_valid, bus.s_r_valid}), 128'(0));
        chk("midrst_readys", 128'({bus.s_aw_ready, bus.s_ar_ready, bus.s_w_ready, bus.dma_read_chnl_ready}), 128'(0));
        chk("midrst_r_id", 128'(bus.s_r_id), 128'(0));
        rst = 1'b1;
        repeat (5) @(negedge clk);
        chk("postrst_rctrl_idle", 128'(bus.dma_read_ctrl_valid), 128'(0));
        chk("postrst_ar_ready", 128'(bus.s_ar_ready), 128'(1));
        chk("postrst_r_valid", 128'({bus.s_r_valid, bus.s_b_valid}), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/axi_esp_dma_bridge.md
Name: axi_esp_dma_bridge

Overview:
AXI4 slave-to-ESP DMA bridge with independent, concurrent read and write paths. Each AR/AW request is queued in its own pending FIFO and issued as one ESP DMA control transaction. Data is then streamed beat-by-beat and a proper AXI response (R with RLAST, or B) is generated. Sits between the cluster AXI master port and the ESP accelerator DMA interface.

Parameters:
AXI_ADDR_WIDTH, 32, AXI address width
AXI_DATA_WIDTH, 64, AXI and DMA data width; power of two, 32..512
AXI_ID_WIDTH, 4, AXI ID width
PENDING_DEPTH, 4, per-direction pending-request FIFO depth; power of two, >=2

Ports:
clk  in  1  clock
rst  in  1  synchronous active-low reset
s_aw_valid/s_aw_ready  in/out  1  AW handshake
s_aw_id  in  AXI_ID_WIDTH  write ID
s_aw_addr  in  AXI_ADDR_WIDTH  write byte address
s_aw_len  in  8  beats-1
s_aw_size  in  3  log2 bytes per beat
s_w_valid/s_w_ready  in/out  1  W handshake
s_w_data  in  AXI_DATA_WIDTH  write data
s_w_strb  in  AXI_DATA_WIDTH/8  byte strobes
s_w_last  in  1  last write beat
s_b_valid/s_b_ready  out/in  1  B handshake
s_b_id  out  AXI_ID_WIDTH  response ID
s_b_resp  out  2  OKAY=00 / SLVERR=10
s_ar_valid/s_ar_ready, s_ar_id, s_ar_addr, s_ar_len, s_ar_size  as AW, for reads
s_r_valid/s_r_ready  out/in  1  R handshake
s_r_data  out  AXI_DATA_WIDTH  read data
s_r_id  out  AXI_ID_WIDTH  read ID
s_r_resp  out  2  always OKAY
s_r_last  out  1  last read beat
dma_read_ctrl_valid/ready  out/in  1; dma_read_ctrl_data_index out 32; _length out 32; _size out 3
dma_read_chnl_valid/ready  in/out  1; dma_read_chnl_data  in  AXI_DATA_WIDTH
dma_write_ctrl_valid/ready  out/in  1; dma_write_ctrl_data_index out 32; _length out 32; _size out 3
dma_write_chnl_valid/ready  out/in  1; dma_write_chnl_data  out  AXI_DATA_WIDTH

Behaviour:
- Reset (rst=0 at posedge): both FIFOs empty, both FSMs idle. All valid/ready outputs are 0. All data, ID and index outputs are 0.
- Request capture: s_aw_ready = !aw_fifo_full and s_ar_ready = !ar_fifo_full. Each FIFO stores {id, addr, len, size}. Push-while-full does not occur. Pop and push in the same cycle are both honoured. Pointers wrap modulo PENDING_DEPTH; fill count is log2(PENDING_DEPTH)+1 bits.
- Control mapping:
  - index = addr >> log2(AXI_DATA_WIDTH/8), zero-extended or truncated to 32 bits.
  - length = len+1, 32 bits.
  - size = stored size.
  - Control outputs are registered from the FIFO head and held stable while ctrl_valid=1.
- Write FSM W_IDLE -> W_CTRL -> W_DATA -> W_RESP -> W_IDLE:
  - W_IDLE: if the AW FIFO is non-empty, pop it and load the control registers; next state W_CTRL. Latency from AW handshake to dma_write_ctrl_valid is 2 cycles.
  - W_CTRL: dma_write_ctrl_valid=1 until ready; then W_DATA and clear the beat counter.
  - W_DATA: dma_write_chnl_valid = s_w_valid and s_w_ready = dma_write_chnl_ready (combinational pass-through). Data bytes with strb=0 are forced to 0x00. Each handshake increments a 9-bit counter.
  - Leave W_DATA on the handshake of beat len+1. If s_w_last on that beat is not 1, or s_w_last arrived earlier, latch an error flag. Early-last beats still count; no beats are dropped.
  - W_RESP: s_b_valid=1 with the stored ID and resp = error ? 10 : 00. Hold until s_b_ready, then W_IDLE.
  - W beats arriving outside W_DATA are stalled (s_w_ready=0).
- Read FSM R_IDLE -> R_CTRL -> R_DATA -> R_IDLE:
  - R_IDLE and R_CTRL mirror the write FSM using the AR FIFO.
  - R_DATA: s_r_valid = dma_read_chnl_valid and dma_read_chnl_ready = s_r_ready (pass-through). s_r_data = chnl data, s_r_id = stored ID, s_r_resp = 00.
  - s_r_last = 1 when the counter equals len. Return to R_IDLE on that handshake.
- Read and write paths are fully independent; simultaneous AW and AR are both accepted in the same cycle.
- Back-to-back bursts: a new burst may be popped in the cycle after W_RESP/R_DATA completes.
- len=0 gives length 1, with s_r_last on the first beat.
- Reset mid-burst aborts all state; no B/R completes, and queued requests are discarded.

Test Plan:
1. AW{id=3, addr=0x100, len=3, size=3}, 4 W beats with full strb and last on beat 4 -> ctrl index=0x20, length=4, size=3. 4 chnl beats. B id=3, resp=00.
2. AR{id=5, addr=0x40, len=0}, DMA returns 0xDEAD -> ctrl index=8, length=1. One R beat: data=0xDEAD, id=5, last=1.
3. Write with strb=0x0F, data=0x1122334455667788 -> dma_write_chnl_data=0x0000000055667788.
4. Issue 5 ARs with dma_read_ctrl_ready=0 and PENDING_DEPTH=4 -> first popped, 4 queued, 6th-cycle s_ar_ready=0. Release ready -> all complete in order with correct IDs and r_last.
5. Concurrent AW(len=1) and AR(len=1) in the same cycle with random backpressure on both DMA channels -> both accepted. B and 2 R beats complete independently.
6. AW len=2 with s_w_last on beat 2 -> 3 beats forwarded, B resp=10. Reset asserted mid-read -> all valids 0 next cycle, FIFOs empty.
